// File: rtl/core_run_pkg.sv
// core_run_pkg: shared types for the core run controller.
// Run-state encoding, end-reason encoding and end-condition arbitration.
package core_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } run_state_e;

    typedef enum logic [1:0] {
        END_NONE,
        END_TOHOST,
        END_HALT,
        END_TIMEOUT
    } end_reason_e;

    // Tohost store beats a halt loop, which beats the cycle budget.
    function automatic end_reason_e pick_end(
        input logic tohost,
        input logic halt,
        input logic tmo
    );
        end_reason_e r;
        r = END_NONE;
        if (tohost) begin
            r = END_TOHOST;
        end else if (halt) begin
            r = END_HALT;
        end else if (tmo) begin
            r = END_TIMEOUT;
        end
        return r;
    endfunction

endpackage

// File: rtl/core_run_ctrl_trace.sv
// pc_trace_buf: circular buffer of the PCs seen in RUN cycles.
// Only built when RUN_TRACE_EN is defined; index 0 reads the newest entry.
module pc_trace_buf #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wr_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    output logic [PC_W-1:0]          pc_o
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]   wptr_q;
    logic [IW-1:0]   rd_ptr;

    // Clearing zeroes every slot so unwritten entries read back as 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_i) begin
            mem_q[wptr_q] <= pc_i;
            wptr_q        <= wptr_q + IW'(1);
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign rd_ptr = wptr_q - IW'(1) - idx_i;
    assign pc_o   = mem_q[rd_ptr];

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences core reset, runs the core, reports the result.
// Define RUN_TRACE_EN to add the PC trace buffer and trace_idx/trace_pc ports.
module core_run_ctrl #(
    parameter int unsigned      PC_W        = 32,
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      CNT_W       = 32,
    parameter int unsigned      RST_CYCLES  = 2,
    parameter int unsigned      MAX_CYCLES  = 1000,
    parameter int unsigned      HALT_REPEAT = 2,
`ifdef RUN_TRACE_EN
    parameter int unsigned      TRACE_DEPTH = 8,
`endif
    parameter logic [PC_W-1:0]  TOHOST_ADDR = 'h100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              mem_we_i,
    input  logic [PC_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              core_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] exit_code_o,
    output logic [CNT_W-1:0]  cycle_count_o
`ifdef RUN_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [PC_W-1:0]                trace_pc_o
`endif
);

    import core_run_pkg::*;

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned HW = $clog2(HALT_REPEAT + 1);

    run_state_e        state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0]     halt_q, halt_d, halt_nxt;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic              seen_q, seen_d;
    logic              pass_q, pass_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] exit_q, exit_d;
    end_reason_e       why;

    // Next-state, counters and end-condition resolution.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        halt_d    = halt_q;
        prev_pc_d = prev_pc_q;
        seen_d    = seen_q;
        pass_d    = pass_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        exit_d    = exit_q;
        why       = END_NONE;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        halt_nxt  = (seen_q && (pc_i == prev_pc_q)) ? halt_q + HW'(1) : '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    cnt_d     = '0;
                    halt_d    = '0;
                    prev_pc_d = '0;
                    seen_d    = 1'b0;
                    pass_d    = 1'b0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                    exit_d    = '0;
                end
            end
            RESET: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            RUN: begin
                cnt_d     = cnt_inc;
                halt_d    = halt_nxt;
                prev_pc_d = pc_i;
                seen_d    = 1'b1;
                why = pick_end(mem_we_i && (mem_addr_i == TOHOST_ADDR),
                               halt_nxt >= HW'(HALT_REPEAT),
                               cnt_inc == CNT_W'(MAX_CYCLES));
                unique case (why)
                    END_TOHOST: begin
                        exit_d = mem_wdata_i;
                        pass_d = (mem_wdata_i == DATA_W'(1));
                    end
                    END_HALT:    halted_d  = 1'b1;
                    END_TIMEOUT: timeout_d = 1'b1;
                    default: ;
                endcase
                if (why != END_NONE) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            halt_q    <= '0;
            prev_pc_q <= '0;
            seen_q    <= 1'b0;
            pass_q    <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            exit_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            halt_q    <= halt_d;
            prev_pc_q <= prev_pc_d;
            seen_q    <= seen_d;
            pass_q    <= pass_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            exit_q    <= exit_d;
        end
    end

    assign core_rst_n_o  = (state_q == RUN);
    assign busy_o        = (state_q == RESET) || (state_q == RUN);
    assign done_o        = (state_q == DONE);
    assign pass_o        = pass_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
    assign exit_code_o   = exit_q;
    assign cycle_count_o = cnt_q;

`ifdef RUN_TRACE_EN
    logic trace_clr;
    logic trace_wr;

    assign trace_clr = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign trace_wr  = (state_q == RUN);

    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (trace_clr),
        .wr_i  (trace_wr),
        .pc_i  (pc_i),
        .idx_i (trace_idx_i),
        .pc_o  (trace_pc_o)
    );
`endif

endmodule
